// File: rtl/cu_pkg.sv
// Shared control-unit definitions: FSM states, ALU opcode constants, strobe bundle.
package cu_pkg;

    typedef enum logic [2:0] {
        FETCH0, FETCH1, FETCH2, EX3, EX4, EX5, EX6, HALTED
    } cu_state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {
        CLS_NOP, CLS_ALU2, CLS_UNARY, CLS_MULDIV, CLS_HALT
    } op_class_t;

    typedef struct packed {
        logic pc_out;
        logic zlo_out;
        logic zhi_out;
        logic mdr_out;
        logic mar_in;
        logic z_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic hi_in;
        logic lo_in;
        logic inc_pc;
        logic read;
        logic run;
    } cu_strobe_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:  op_class = CLS_ALU2;
            OP_NEG, OP_NOT:                 op_class = CLS_UNARY;
            OP_MUL, OP_DIV:                 op_class = CLS_MULDIV;
            OP_HALT:                        op_class = CLS_HALT;
            OP_NOP:                         op_class = CLS_NOP;
            default:                        op_class = CLS_NOP;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control unit <-> datapath bundle: master is the control unit, slave the datapath.
interface control_unit_if;
    logic [31:0] IR;
    logic        mem_rdy;
    logic        PCout, Zlowout, Zhighout, MDRout;
    logic        MARIn, ZIn, PCIn, MDRIn, IRIn, YIn, HiIn, LoIn;
    logic        IncPC, read, run;
    logic [15:0] Rin, Rout;
    logic [4:0]  opcode;

    modport master (
        input  IR, mem_rdy,
        output PCout, Zlowout, Zhighout, MDRout,
        output MARIn, ZIn, PCIn, MDRIn, IRIn, YIn, HiIn, LoIn,
        output IncPC, read, run, Rin, Rout, opcode
    );

    modport slave (
        output IR, mem_rdy,
        input  PCout, Zlowout, Zhighout, MDRout,
        input  MARIn, ZIn, PCIn, MDRIn, IRIn, YIn, HiIn, LoIn,
        input  IncPC, read, run, Rin, Rout, opcode
    );
endinterface

// File: rtl/reg_decoder_4_to_16.sv
// 4-bit register field to one-hot 16-bit select, forced to zero when disabled.
module reg_decoder_4_to_16 (
    input  logic [3:0]  i_sel,
    input  logic        i_en,
    output logic [15:0] o_onehot
);
    for (genvar n = 0; n < 16; n++) begin : g_bit
        assign o_onehot[n] = i_en && (i_sel == 4'(n));
    end
endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute control unit with registered Moore strobes.
// Define CU_MEM_WAIT_EN to stretch FETCH1 until mem_rdy is seen.
module control_unit
    import cu_pkg::*;
(
    input  logic           clk,
    input  logic           clr,
    control_unit_if.master cu_bus
);
    cu_state_t   r_state, w_nxt;
    cu_strobe_t  r_stb, w_stb;
    logic [15:0] r_rin, r_rout, w_rin, w_rout;
    logic [4:0]  r_op, w_op;
    logic [3:0]  w_rin_sel, w_rout_sel;
    logic        w_rin_en, w_rout_en;
    logic [3:0]  w_ra, w_rb, w_rc;
    op_class_t   w_cls;
    logic        w_unused;

    assign w_ra     = cu_bus.IR[26:23];
    assign w_rb     = cu_bus.IR[22:19];
    assign w_rc     = cu_bus.IR[18:15];
    assign w_cls    = op_class(cu_bus.IR[31:27]);
    assign w_unused = ^{cu_bus.IR[14:0], cu_bus.mem_rdy};

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            FETCH0: w_nxt = FETCH1;
`ifdef CU_MEM_WAIT_EN
            FETCH1: w_nxt = cu_bus.mem_rdy ? FETCH2 : FETCH1;
`else
            FETCH1: w_nxt = FETCH2;
`endif
            FETCH2: w_nxt = EX3;
            EX3: begin
                case (w_cls)
                    CLS_ALU2, CLS_UNARY, CLS_MULDIV: w_nxt = EX4;
                    CLS_HALT:                        w_nxt = HALTED;
                    default:                         w_nxt = FETCH0;
                endcase
            end
            EX4:     w_nxt = (w_cls == CLS_ALU2 || w_cls == CLS_MULDIV) ? EX5 : FETCH0;
            EX5:     w_nxt = (w_cls == CLS_MULDIV) ? EX6 : FETCH0;
            EX6:     w_nxt = FETCH0;
            HALTED:  w_nxt = HALTED;
            default: w_nxt = FETCH0;
        endcase
        // FETCH0 with run low is the post-clear hold; the first real cycle is FETCH0 again
        if (r_state == FETCH0 && !r_stb.run) w_nxt = FETCH0;
    end

    // Strobes for the state being entered, so they are registered alongside it
    always_comb begin
        w_stb      = '0;
        w_stb.run  = 1'b1;
        w_op       = '0;
        w_rin_en   = 1'b0;
        w_rout_en  = 1'b0;
        w_rin_sel  = w_ra;
        w_rout_sel = w_rb;
        case (w_nxt)
            FETCH0: begin
                w_stb.pc_out = 1'b1;
                w_stb.mar_in = 1'b1;
                w_stb.inc_pc = 1'b1;
                w_stb.z_in   = 1'b1;
            end
            FETCH1: begin
                w_stb.zlo_out = 1'b1;
                w_stb.read    = 1'b1;
                w_stb.mdr_in  = 1'b1;
                w_stb.pc_in   = (r_state != FETCH1);
            end
            FETCH2: begin
                w_stb.mdr_out = 1'b1;
                w_stb.ir_in   = 1'b1;
            end
            EX3: begin
                case (w_cls)
                    CLS_ALU2: begin
                        w_rout_en  = 1'b1;
                        w_stb.y_in = 1'b1;
                    end
                    CLS_UNARY: begin
                        w_rout_en  = 1'b1;
                        w_op       = cu_bus.IR[31:27];
                        w_stb.z_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_ra;
                        w_stb.y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            EX4: begin
                case (w_cls)
                    CLS_ALU2, CLS_MULDIV: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = (w_cls == CLS_ALU2) ? w_rc : w_rb;
                        w_op       = cu_bus.IR[31:27];
                        w_stb.z_in = 1'b1;
                    end
                    CLS_UNARY: begin
                        w_stb.zlo_out = 1'b1;
                        w_rin_en      = 1'b1;
                    end
                    default: ;
                endcase
            end
            EX5: begin
                w_stb.zlo_out = 1'b1;
                w_rin_en      = (w_cls == CLS_ALU2);
                w_stb.lo_in   = (w_cls == CLS_MULDIV);
            end
            EX6: begin
                w_stb.zhi_out = 1'b1;
                w_stb.hi_in   = 1'b1;
            end
            HALTED:  w_stb.run = 1'b0;
            default: ;
        endcase
    end

    reg_decoder_4_to_16 u_rin_dec  (.i_sel(w_rin_sel),  .i_en(w_rin_en),  .o_onehot(w_rin));
    reg_decoder_4_to_16 u_rout_dec (.i_sel(w_rout_sel), .i_en(w_rout_en), .o_onehot(w_rout));

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= FETCH0;
            r_stb   <= '0;
            r_rin   <= '0;
            r_rout  <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_nxt;
            r_stb   <= w_stb;
            r_rin   <= w_rin;
            r_rout  <= w_rout;
            r_op    <= w_op;
        end
    end

    assign cu_bus.PCout    = r_stb.pc_out;
    assign cu_bus.Zlowout  = r_stb.zlo_out;
    assign cu_bus.Zhighout = r_stb.zhi_out;
    assign cu_bus.MDRout   = r_stb.mdr_out;
    assign cu_bus.MARIn    = r_stb.mar_in;
    assign cu_bus.ZIn      = r_stb.z_in;
    assign cu_bus.PCIn     = r_stb.pc_in;
    assign cu_bus.MDRIn    = r_stb.mdr_in;
    assign cu_bus.IRIn     = r_stb.ir_in;
    assign cu_bus.YIn      = r_stb.y_in;
    assign cu_bus.HiIn     = r_stb.hi_in;
    assign cu_bus.LoIn     = r_stb.lo_in;
    assign cu_bus.IncPC    = r_stb.inc_pc;
    assign cu_bus.read     = r_stb.read;
    assign cu_bus.run      = r_stb.run;
    assign cu_bus.Rin      = r_rin;
    assign cu_bus.Rout     = r_rout;
    assign cu_bus.opcode   = r_op;

endmodule
